// File: rtl/if_id_fifo_pkg.sv
// if_id_fifo_pkg
// Shared definitions for the fetch/decode instruction queue: fetch exception
// codes, the NOP word presented when the queue is empty, the fetch reset PC
// and the packed layout of one queued entry.
package if_id_fifo_pkg;

    // Fetch exception codes, encoded {addr_error, addr_fault}
    localparam logic [1:0] EXC_NONE       = 2'b00;
    localparam logic [1:0] EXC_ADDR_FAULT = 2'b01;
    localparam logic [1:0] EXC_ADDR_ERROR = 2'b10;

    // Word presented to decode when nothing is queued
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Boot vector used by fetch after reset
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    // One queued entry, 66 bits: {exc, pc, inst}
    typedef struct packed {
        logic [1:0]  exc;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// if_id_fifo
// Instruction queue between fetch and decode. Buffers up to DEPTH fetched
// words together with their PC and fetch exception code and presents the
// oldest one to decode in show-ahead form. A flush discards every entry.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-low; empties the queue
//   flush      synchronous discard of all entries
//   in_valid   fetch presents an instruction
//   in_inst    fetched instruction word
//   in_pc      PC of in_inst
//   in_exc     fetch exception code {addr_error, addr_fault}
//   in_ready   queue can accept this cycle
//   out_valid  head entry valid
//   out_inst   head instruction (NOP when empty)
//   out_pc     head PC (0 when empty)
//   out_exc    head exception code (EXC_NONE when empty)
//   out_ready  decode consumes the head this cycle
//   count      current occupancy
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    input  logic [1:0]               in_exc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [1:0]               out_exc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    fetch_entry_t   head;
    logic           push;
    logic           pop;

    // Ready comes only from the registered count, so a full queue refuses a
    // push even in a cycle where decode pops.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is never cleared; only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{exc: in_exc, pc: in_pc, inst: in_inst};
        end
    end

    assign head = mem[rd_ptr];

    // An empty queue shows a clean NOP instead of whatever stale word sits
    // under the read pointer.
    always_comb begin
        out_inst = NOP_WORD;
        out_pc   = 32'h0000_0000;
        out_exc  = EXC_NONE;
        if (out_valid) begin
            out_inst = head.inst;
            out_pc   = head.pc;
            out_exc  = head.exc;
        end
    end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Instruction queue between the fetch stage and the decode stage. Accepts fetched words with their PC and fetch-exception code, buffers up to DEPTH entries, and presents the oldest entry to decode in show-ahead form. Absorbs decode stalls without freezing fetch every cycle, and discards its whole contents on a flush caused by an interrupt/exception or a taken branch/jump.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears the queue
- flush  in  1  synchronous discard of all entries (interrupt, taken branch/jump)
- in_valid  in  1  fetch presents a real instruction (bubbles arrive with in_valid=0)
- in_inst  in  32  fetched instruction word
- in_pc  in  32  PC of in_inst
- in_exc  in  2  fetch exception code {addr_error, addr_fault}
- in_ready  out  1  queue can accept this cycle
- out_valid  out  1  head entry valid
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- out_exc  out  2  head exception code
- out_ready  in  1  decode consumes head this cycle
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH), purely from registered count; no pass-through when full, even if a pop occurs the same cycle.
- out_valid = (count != 0); out_* driven combinationally from the entry at the read pointer.
- When empty: out_inst = 32'h0000_0000 (NOP), out_pc = 0, out_exc = 2'b00, regardless of stale storage.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers log2(DEPTH) bits, wrap modulo DEPTH naturally; count saturates by construction (push blocked at DEPTH, pop blocked at 0).
- Entries with in_exc ≠ 0 are queued like any other; the code travels with its PC and instruction to decode unchanged.
- Flush has priority over push and pop: at the edge, count, read and write pointers go to 0; a push or pop presented in the flush cycle is ignored.
- Storage contents are not cleared by flush or reset; only pointers/count are.

## Timing
- Reset (async assert, any time): count = 0, pointers = 0, in_ready = 1, out_valid = 0, out_inst/out_pc = 0, out_exc = 0. Mid-operation reset discards all entries immediately, not waiting for a clock.
- Latency: push at edge N makes the entry visible on out_* after edge N (one cycle); no empty-queue bypass.
- Pop at edge N exposes the next entry after edge N.
- Flush at edge N: out_valid = 0 and in_ready = 1 after edge N; first post-flush push may be accepted in cycle N+1.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.

## Structure
- Shared package: fetch exception codes (EXC_NONE = 2'b00, EXC_ADDR_FAULT = 2'b01, EXC_ADDR_ERROR = 2'b10), NOP word constant 32'h0, reset PC constant 32'hbfc0_0000 for consistency with fetch.
- Storage as one DEPTH × 66-bit array {exc, pc, inst} inside the module; no sub-module needed.

## Test plan
- Reset released, push 0x2408_0001 @ pc 0xbfc0_0000 with out_ready=0 -> next cycle out_valid=1, out_inst=0x2408_0001, out_pc=0xbfc0_0000, count=1.
- Push 4 entries (pc 0xbfc0_0000..0xbfc0_000c) with out_ready=0 -> count=4, in_ready=0; fifth push ignored; then pop 4 -> PCs emerge in order, count=0, out_inst=0.
- Hold count=2, push+pop together for 10 cycles -> count stays 2, PCs strictly in order across pointer wrap.
- count=3, assert flush with simultaneous in_valid and out_ready -> after edge count=0, out_valid=0, flushed-cycle entry not present.
- Push entry with in_exc=2'b10 @ pc 0xbfc0_0002 -> emerges with out_exc=2'b10, out_pc=0xbfc0_0002.
- count=2, assert reset between clock edges -> out_valid=0, count=0 immediately, before next rising edge.
